// File: rtl/vga_sync_gen_pkg.sv
// Shared counter width, default 640x480@60 timings and a window-decode helper
// for the VGA sync generator and its wrap counter.
package vga_sync_gen_pkg;

    localparam int COUNT_W   = 10;
    localparam int MAX_TOTAL = 1 << COUNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [COUNT_W-1:0] coord_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input coord_t pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_wrap_counter.sv
// Modulo counter with an advance enable; wrap pulses on the step from MODULUS-1 back to 0.
// count_next exposes the value the counter takes on the coming edge.
module vga_sync_gen_wrap_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int MODULUS = 800
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] count_next,
    output logic               wrap
);

    localparam coord_t LAST = coord_t'(MODULUS - 1);

    always_comb begin
        wrap       = inc && (count == LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count + 1'b1;
        end
    end

    // Reset parks the counter on its last value so the first advance lands on 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: column/row counters plus registered
// sync, active and frame-start flags, all describing the same pixel.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COUNT_W-1:0] col,
    output logic [COUNT_W-1:0] row,
    output logic               frame_start
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
    endgenerate

    logic [COUNT_W-1:0] col_next;
    logic [COUNT_W-1:0] row_next;
    logic               col_wrap;
    logic               row_wrap;

    vga_sync_gen_wrap_counter #(
        .MODULUS(H_TOTAL)
    ) u_col (
        .clk       (clk),
        .reset     (reset),
        .inc       (1'b1),
        .count     (col),
        .count_next(col_next),
        .wrap      (col_wrap)
    );

    vga_sync_gen_wrap_counter #(
        .MODULUS(V_TOTAL)
    ) u_row (
        .clk       (clk),
        .reset     (reset),
        .inc       (col_wrap),
        .count     (row),
        .count_next(row_next),
        .wrap      (row_wrap)
    );

    // Flags decode the counters' next values so they line up with col/row after the edge.
    // The row only wraps together with the column, so row_wrap marks the step into (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= in_window(col_next, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= in_window(row_next, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            active      <= in_window(col_next, 0, H_ACTIVE) && in_window(row_next, 0, V_ACTIVE);
            frame_start <= row_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: default, medium and tiny timings run side by side against
// a per-cycle scoreboard model, plus a fixed vector table and frame statistics.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    import vga_sync_gen_pkg::*;

    localparam int NCFG = 3;
    localparam int   H_ACT [NCFG] = '{640, 64, 4};
    localparam int   H_FPR [NCFG] = '{16, 4, 1};
    localparam int   H_SYN [NCFG] = '{96, 8, 2};
    localparam int   H_BPR [NCFG] = '{48, 4, 1};
    localparam int   V_ACT [NCFG] = '{480, 48, 3};
    localparam int   V_FPR [NCFG] = '{10, 2, 1};
    localparam int   V_SYN [NCFG] = '{2, 2, 1};
    localparam int   V_BPR [NCFG] = '{33, 3, 1};
    localparam logic SA    [NCFG] = '{1'b0, 1'b0, 1'b1};
    localparam int   RUN_CYCLES = 8801;

    typedef struct packed {
        logic [COUNT_W-1:0] col;
        logic [COUNT_W-1:0] row;
        logic               hsync;
        logic               vsync;
        logic               active;
        logic               frame_start;
    } pix_t;

    typedef struct {
        logic rst;
        int   cycles;
        pix_t exp;
    } vec_t;

    logic               clk;
    logic               reset;
    logic               hsync_s  [NCFG];
    logic               vsync_s  [NCFG];
    logic               active_s [NCFG];
    logic               fs_s     [NCFG];
    logic [COUNT_W-1:0] col_s    [NCFG];
    logic [COUNT_W-1:0] row_s    [NCFG];

    int   checks = 0;
    int   errors = 0;
    int   m_col [NCFG];
    int   m_row [NCFG];
    pix_t exp_q [$];
    vec_t vecs  [12];

    int   last_fs [NCFG];
    int   fs_seen [NCFG];
    int   act_acc [NCFG];
    int   vs_acc  [NCFG];
    int   hs_run  [NCFG];
    logic prev_hs [NCFG];
    logic prev_vs [NCFG];
    logic prev_act[NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        vga_sync_gen #(
            .H_ACTIVE   (H_ACT[g]),
            .H_FP       (H_FPR[g]),
            .H_SYNC     (H_SYN[g]),
            .H_BP       (H_BPR[g]),
            .V_ACTIVE   (V_ACT[g]),
            .V_FP       (V_FPR[g]),
            .V_SYNC     (V_SYN[g]),
            .V_BP       (V_BPR[g]),
            .SYNC_ACTIVE(SA[g])
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .hsync      (hsync_s[g]),
            .vsync      (vsync_s[g]),
            .active     (active_s[g]),
            .col        (col_s[g]),
            .row        (row_s[g]),
            .frame_start(fs_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int h_total(input int k);
        return H_ACT[k] + H_FPR[k] + H_SYN[k] + H_BPR[k];
    endfunction

    function automatic int v_total(input int k);
        return V_ACT[k] + V_FPR[k] + V_SYN[k] + V_BPR[k];
    endfunction

    // Expected outputs for the pixel the model currently sits on.
    function automatic pix_t model_out(input int k, input int c, input int r);
        pix_t p;
        logic hs_on;
        logic vs_on;
        hs_on = (c >= H_ACT[k] + H_FPR[k]) && (c < H_ACT[k] + H_FPR[k] + H_SYN[k]);
        vs_on = (r >= V_ACT[k] + V_FPR[k]) && (r < V_ACT[k] + V_FPR[k] + V_SYN[k]);
        p.col         = COUNT_W'(c);
        p.row         = COUNT_W'(r);
        p.hsync       = hs_on ? SA[k] : ~SA[k];
        p.vsync       = vs_on ? SA[k] : ~SA[k];
        p.active      = (c < H_ACT[k]) && (r < V_ACT[k]);
        p.frame_start = (c == 0) && (r == 0);
        return p;
    endfunction

    task automatic model_step(input int k, input logic rst);
        if (rst) begin
            m_col[k] = h_total(k) - 1;
            m_row[k] = v_total(k) - 1;
        end else if (m_col[k] == h_total(k) - 1) begin
            m_col[k] = 0;
            m_row[k] = (m_row[k] == v_total(k) - 1) ? 0 : m_row[k] + 1;
        end else begin
            m_col[k] = m_col[k] + 1;
        end
    endtask

    function automatic pix_t actual(input int k);
        return {col_s[k], row_s[k], hsync_s[k], vsync_s[k], active_s[k], fs_s[k]};
    endfunction

    task automatic check_output();
        pix_t e;
        pix_t a;
        for (int k = 0; k < NCFG; k++) begin
            e = exp_q.pop_front();
            a = actual(k);
            checks++;
            if (a !== e) begin
                errors++;
                $display("[TB] FAIL model_cfg%0d t=%0t got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b",
                         k, $time, a.col, a.row, a.hsync, a.vsync, a.active, a.frame_start,
                         e.col, e.row, e.hsync, e.vsync, e.active, e.frame_start);
            end
        end
    endtask

    task automatic apply_stimulus(input logic rst, input int n);
        for (int i = 0; i < n; i++) begin
            reset = rst;
            for (int k = 0; k < NCFG; k++) begin
                model_step(k, rst);
                exp_q.push_back(model_out(k, m_col[k], m_row[k]));
            end
            @(posedge clk);
            #1;
            check_output();
        end
    endtask

    task automatic check_int(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s cfg%0d t=%0t got %0d expected %0d", name, k, $time, got, want);
        end
    endtask

    function automatic vec_t mk(input logic rst, input int n, input int c, input int r,
                                input logic hs, input logic vs, input logic act, input logic fs);
        vec_t v;
        v.rst = rst;
        v.cycles = n;
        v.exp = {COUNT_W'(c), COUNT_W'(r), hs, vs, act, fs};
        return v;
    endfunction

    // Frame/line statistics gathered from the DUT outputs of configuration k.
    task automatic track(input int k, input int cyc);
        logic hs_on;
        logic vs_on;
        hs_on = (hsync_s[k] == SA[k]);
        vs_on = (vsync_s[k] == SA[k]);
        if (fs_s[k]) begin
            if (fs_seen[k] > 0) begin
                check_int("frame_period", k, cyc - last_fs[k], h_total(k) * v_total(k));
                check_int("active_per_frame", k, act_acc[k], H_ACT[k] * V_ACT[k]);
                check_int("vsync_per_frame", k, vs_acc[k], V_SYN[k] * h_total(k));
            end
            fs_seen[k]++;
            last_fs[k] = cyc;
            act_acc[k] = 0;
            vs_acc[k]  = 0;
        end
        if (active_s[k]) act_acc[k]++;
        if (vs_on) vs_acc[k]++;
        if (vs_on && !prev_vs[k]) begin
            check_int("vsync_start_col", k, int'(col_s[k]), 0);
            check_int("vsync_start_row", k, int'(row_s[k]), V_ACT[k] + V_FPR[k]);
        end
        if (hs_on && !prev_hs[k]) begin
            check_int("hsync_start_col", k, int'(col_s[k]), H_ACT[k] + H_FPR[k]);
            hs_run[k] = 0;
        end
        if (hs_on) hs_run[k]++;
        if (!hs_on && prev_hs[k]) check_int("hsync_width", k, hs_run[k], H_SYN[k]);
        if (!active_s[k] && prev_act[k]) check_int("active_end_col", k, int'(col_s[k]), H_ACT[k]);
        prev_hs[k]  = hs_on;
        prev_vs[k]  = vs_on;
        prev_act[k] = active_s[k];
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        pix_t a;
        reset = 1'b1;
        vecs[0]  = mk(1'b1, 5,    799, 524, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1);
        vecs[2]  = mk(1'b0, 639,  639, 0,   1'b1, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1,    640, 0,   1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 16,   656, 0,   1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 95,   751, 0,   1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1,    752, 0,   1'b1, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 47,   799, 0,   1'b1, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1,    0,   1,   1'b1, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 7500, 300, 10,  1'b1, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1,    799, 524, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].cycles);
            a = actual(0);
            checks++;
            if (a !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL table[%0d] got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b",
                         i, a.col, a.row, a.hsync, a.vsync, a.active, a.frame_start,
                         vecs[i].exp.col, vecs[i].exp.row, vecs[i].exp.hsync,
                         vecs[i].exp.vsync, vecs[i].exp.active, vecs[i].exp.frame_start);
            end
        end

        // Fresh reset, then free-run while collecting frame and line statistics.
        apply_stimulus(1'b1, 3);
        for (int k = 0; k < NCFG; k++) begin
            last_fs[k]  = 0;
            fs_seen[k]  = 0;
            act_acc[k]  = 0;
            vs_acc[k]   = 0;
            hs_run[k]   = 0;
            prev_hs[k]  = 1'b0;
            prev_vs[k]  = 1'b0;
            prev_act[k] = 1'b0;
        end
        for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
            apply_stimulus(1'b0, 1);
            for (int k = 0; k < NCFG; k++) track(k, cyc);
        end
        for (int k = 0; k < NCFG; k++) begin
            check_int("frame_start_count", k, fs_seen[k],
                      (RUN_CYCLES - 1) / (h_total(k) * v_total(k)) + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
